// File: rtl/ula_pkg.sv
// Shared ALU definitions: operation codes and the control-state encoding,
// reused by the processor datapath as well as the multi-cycle ALU.
package ula_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_MUL = 3'b110,
        OP_RSV = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/ula_mult_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle; done_o pulses on the
// WIDTH-th iteration with product_o valid combinationally in that cycle; no backpressure.
module ula_mult_seq #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d;
    logic [2*WIDTH-1:0] partial;
    logic               last;

    assign partial   = mplier_q[0] ? mcand_q : '0;
    assign last      = run_q && (cnt_q == CW'(WIDTH - 1));
    assign done_o    = last;
    // The final partial sum is handed out directly so the caller can capture it on this edge.
    assign product_o = acc_q + partial;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: result 1 cycle after accept (MUL: WIDTH+1); one op in flight.
// Result held in DONE until out_ready; in_ready only in IDLE.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;

    op_e                op_v;
    logic               sub_op;
    logic [WIDTH-1:0]   b_x;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign op_v   = op_e'(op);
    assign sub_op = (op_v == OP_SUB);
    // SUB reuses the adder as a + ~b + 1, so carry-out means "no borrow".
    assign b_x    = sub_op ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub_op};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_v)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = '0;
        endcase
    end

    ula_mult_seq #(
        .WIDTH(WIDTH)
    ) u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (a),
        .b_i       (b),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (op_v == OP_MUL) begin
                        state_d   = ST_CALC;
                        mul_start = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = alu_res;
                        carry_d  = alu_c;
                        ovf_d    = alu_v;
                    end
                end
            end
            ST_CALC: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    result_d = mul_prod[WIDTH-1:0];
                    carry_d  = |mul_prod[2*WIDTH-1:WIDTH];
                    ovf_d    = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d  = ST_IDLE;
                    result_d = '0;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = out_valid ? result_q : '0;
    assign zero      = out_valid && (result_q == '0);
    assign negative  = out_valid && result_q[WIDTH-1];
    assign carry     = out_valid && carry_q;
    assign overflow  = out_valid && ovf_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Bench for ula_multiciclo at WIDTH=64 and WIDTH=8: stimulus pushes expectations
// from an arithmetic reference model, per-instance monitors pop and compare.
module tb_ula_multiciclo;

    typedef struct {
        logic [63:0] res;
        logic        z, n, c, v;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        iv64, ir64, ov64, or64, z64, n64, c64, v64, bz64;
    logic [63:0] a64, b64, res64;
    logic [2:0]  op64;
    logic        iv8, ir8, ov8, or8, z8, n8, c8, v8, bz8;
    logic [7:0]  a8, b8, res8;
    logic [2:0]  op8;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   rnd_rdy = 0;
    logic man_rdy64 = 1'b1;
    logic man_rdy8  = 1'b1;
    exp_t q64[$];
    exp_t q8[$];

    ula_multiciclo #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
        .op(op64), .out_valid(ov64), .out_ready(or64), .result(res64), .zero(z64),
        .negative(n64), .carry(c64), .overflow(v64), .busy(bz64)
    );

    ula_multiciclo #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .op(op8), .out_valid(ov8), .out_ready(or8), .result(res8), .zero(z8),
        .negative(n8), .carry(c8), .overflow(v8), .busy(bz8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        or64 = 1'b1;
        or8  = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            or64 = rnd_rdy ? 1'($urandom_range(0, 1)) : man_rdy64;
            or8  = rnd_rdy ? 1'($urandom_range(0, 1)) : man_rdy8;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [129:0] sval(input logic [63:0] x, input int w);
        logic signed [129:0] r;
        r = $signed({66'd0, x});
        if (x[w-1]) r = r - (130'sd1 <<< w);
        return r;
    endfunction

    // Reference: plain integer arithmetic at width w, operands given zero-extended.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic [2:0] op);
        exp_t e;
        logic [127:0] m, full;
        logic signed [129:0] sa, sb, s, hi, lo;
        m  = (128'd1 << w) - 128'd1;
        sa = sval(a, w);
        sb = sval(b, w);
        hi = (130'sd1 <<< (w - 1)) - 130'sd1;
        lo = -(130'sd1 <<< (w - 1));
        e.res = '0; e.c = 1'b0; e.v = 1'b0;
        case (op)
            3'd0: begin
                full  = {64'd0, a} + {64'd0, b};
                e.res = full[63:0] & m[63:0];
                e.c   = (full >> w) != 0;
                s     = sa + sb;
                e.v   = (s > hi) || (s < lo);
            end
            3'd1: begin
                e.res = (a - b) & m[63:0];
                e.c   = (a >= b);
                s     = sa - sb;
                e.v   = (s > hi) || (s < lo);
            end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = a ^ b;
            3'd5: e.res = (sa < sb) ? 64'd1 : 64'd0;
            3'd6: begin
                full  = {64'd0, a} * {64'd0, b};
                e.res = full[63:0] & m[63:0];
                e.c   = (full >> w) != 0;
            end
            default: e.res = '0;
        endcase
        e.z   = (e.res == 64'd0);
        e.n   = e.res[w-1];
        e.lat = (op == 3'd6) ? w + 1 : 1;
        e.acc = 0;
        return e;
    endfunction

    function automatic int qsize(input int w);
        return (w == 64) ? q64.size() : q8.size();
    endfunction

    task automatic set_in(input int w, input logic v, input logic [63:0] a,
                          input logic [63:0] b, input logic [2:0] op);
        if (w == 64) begin
            iv64 = v; a64 = a; b64 = b; op64 = op;
        end else begin
            iv8 = v; a8 = a[7:0]; b8 = b[7:0]; op8 = op;
        end
    endtask

    // Present a request, push its expectation when the accept edge is known, then scramble inputs.
    task automatic drive(input int w, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] op);
        int   n;
        logic rdy;
        exp_t e;
        e = model(w, a, b, op);
        set_in(w, 1'b1, a, b, op);
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 500) begin
            @(negedge clk);
            rdy = (w == 64) ? ir64 : ir8;
            n++;
        end
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL accept_timeout w=%0d: in_ready got=0 want=1", w);
        end else begin
            e.acc = cyc + 1;
            if (w == 64) q64.push_back(e);
            else q8.push_back(e);
        end
        @(posedge clk);
        #1;
        set_in(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom));
    endtask

    task automatic wait_idle(input int w);
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < 1000) begin
            @(negedge clk);
            done = ((w == 64) ? ir64 : ir8) && (qsize(w) == 0);
            n++;
        end
        chk($sformatf("idle_reached_w%0d", w), {63'd0, done}, 64'd1);
        chk($sformatf("idle_busy_w%0d", w), {63'd0, (w == 64) ? bz64 : bz8}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input int w, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] op);
        drive(w, a, b, op);
        wait_idle(w);
    endtask

    task automatic mon(input int w);
        exp_t        cur;
        bit          seen;
        logic        ov, ordy;
        logic [63:0] rs;
        logic [3:0]  fl;
        seen = 0;
        forever begin
            @(negedge clk);
            if (w == 64) begin
                ov = ov64; ordy = or64; rs = res64; fl = {z64, n64, c64, v64};
            end else begin
                ov = ov8; ordy = or8; rs = {56'd0, res8}; fl = {z8, n8, c8, v8};
            end
            if (!rst_n) begin
                seen = 0;
                continue;
            end
            if (ov) begin
                if (!seen) begin
                    if (qsize(w) == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out w=%0d: result=%h with nothing outstanding", w, rs);
                    end else begin
                        cur  = (w == 64) ? q64.pop_front() : q8.pop_front();
                        seen = 1;
                        chk($sformatf("latency_w%0d", w), 64'(cyc - cur.acc + 1), 64'(cur.lat));
                        chk($sformatf("result_w%0d", w), rs, cur.res);
                        chk($sformatf("flags_zncv_w%0d", w), {60'd0, fl},
                            {60'd0, cur.z, cur.n, cur.c, cur.v});
                    end
                end else begin
                    chk($sformatf("hold_result_w%0d", w), rs, cur.res);
                    chk($sformatf("hold_flags_w%0d", w), {60'd0, fl},
                        {60'd0, cur.z, cur.n, cur.c, cur.v});
                end
                if (ordy) seen = 0;
            end else begin
                chk($sformatf("quiet_result_w%0d", w), rs, 64'd0);
                chk($sformatf("quiet_flags_w%0d", w), {60'd0, fl}, 64'd0);
            end
        end
    endtask

    initial mon(64);
    initial mon(8);

    task automatic chk_reset(input string tag);
        chk({tag, "_ov64"},  {63'd0, ov64}, 64'd0);
        chk({tag, "_res64"}, res64, 64'd0);
        chk({tag, "_fl64"},  {60'd0, z64, n64, c64, v64}, 64'd0);
        chk({tag, "_busy64"}, {63'd0, bz64}, 64'd0);
        chk({tag, "_inrdy64"}, {63'd0, ir64}, 64'd1);
        chk({tag, "_ov8"},   {63'd0, ov8}, 64'd0);
        chk({tag, "_res8"},  {56'd0, res8}, 64'd0);
        chk({tag, "_fl8"},   {60'd0, z8, n8, c8, v8}, 64'd0);
        chk({tag, "_inrdy8"}, {63'd0, ir8}, 64'd1);
    endtask

    function automatic logic [63:0] rnd_val(input int w);
        logic [63:0] m;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFF;
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return m;
            2:       return 64'd1 << (w - 1);
            3:       return m >> 1;
            default: return {$urandom, $urandom} & m;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        set_in(64, 1'b0, 64'd0, 64'd0, 3'd0);
        set_in(8, 1'b0, 64'd0, 64'd0, 3'd0);
        #1;
        chk_reset("por");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run1(64, 64'd3, 64'd2, 3'd0);
        run1(64, 64'd3, 64'd2, 3'd1);
        run1(64, 64'd2, 64'd3, 3'd1);
        run1(64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd5);
        run1(64, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd5);
        run1(64, 64'd6, 64'd7, 3'd6);
        run1(64, 64'hF0F0_1234_5678_00FF, 64'h0FF0_FFFF_0000_F00F, 3'd2);
        run1(64, 64'hF0F0_1234_5678_00FF, 64'h0FF0_FFFF_0000_F00F, 3'd3);
        run1(64, 64'hF0F0_1234_5678_00FF, 64'h0FF0_FFFF_0000_F00F, 3'd4);
        run1(64, 64'h1234, 64'h5678, 3'd7);
        run1(8, 64'h7F, 64'h01, 3'd0);
        run1(8, 64'hFF, 64'h01, 3'd0);
        run1(8, 64'h10, 64'h10, 3'd6);
        run1(8, 64'h80, 64'h01, 3'd1);

        // Result held while the consumer stalls and a new request waits.
        man_rdy64 = 1'b0;
        drive(64, 64'd100, 64'd23, 3'd0);
        set_in(64, 1'b1, 64'hDEAD, 64'hBEEF, 3'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, ir64}, 64'd0);
            chk("stall_out_valid", {63'd0, ov64}, 64'd1);
        end
        @(posedge clk);
        #1;
        man_rdy64 = 1'b1;
        drive(64, 64'hDEAD, 64'hBEEF, 3'd1);
        wait_idle(64);

        // Reset 10 cycles into a multiply, then a clean ADD.
        drive(64, 64'd12345, 64'd678, 3'd6);
        repeat (10) @(posedge clk);
        #1;
        chk("mul_busy_pre", {63'd0, bz64}, 64'd1);
        chk("mul_valid_pre", {63'd0, ov64}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk_reset("abort");
        q64.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run1(64, 64'd3, 64'd2, 3'd0);

        rnd_rdy = 1;
        for (int i = 0; i < 40; i++) run1(64, rnd_val(64), rnd_val(64), 3'($urandom_range(0, 7)));
        for (int i = 0; i < 60; i++) run1(8, rnd_val(8), rnd_val(8), 3'($urandom_range(0, 7)));
        rnd_rdy = 0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
